// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the multi-port data memory, the LSU and the PTW.
//   - Default width/depth constants for the memory.
//   - Init FSM state encodings.
//   - Bit-masked merge helper used by the read-lane forwarding path.
package dmem_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_BYTE_WIDTH = 8;
    localparam int DMEM_ADDR_WIDTH = 10;
    localparam int DMEM_RAM_DEPTH  = 1024;
    localparam int DMEM_NUM_RD     = 2;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int DMEM_MERGE_W    = 256;

    // Init FSM states
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Take new_word where bit_mask is set, old_word elsewhere.
    function automatic logic [DMEM_MERGE_W-1:0] byte_merge(
        input logic [DMEM_MERGE_W-1:0] old_word,
        input logic [DMEM_MERGE_W-1:0] new_word,
        input logic [DMEM_MERGE_W-1:0] bit_mask
    );
        return (new_word & bit_mask) | (old_word & ~bit_mask);
    endfunction

endpackage

// File: rtl/dmem_rd_port.sv
// dmem_rd_port: one registered read lane of the data memory.
//   clk, rst_n : clock, async active-low reset
//   accept     : request accepted this cycle (captures a new read)
//   raddr      : read word address for this lane
//   waddr/wen/wdata : write port of the same request, for write-first forwarding
//   old_word   : current array contents at raddr
//   rdata      : registered read data (0 after reset, holds when idle)
module dmem_rd_port
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int BYTE_WIDTH = DMEM_BYTE_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int RAM_DEPTH  = DMEM_RAM_DEPTH,
    parameter int DATA_BYTE  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_BYTE-1:0]  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] old_word,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic                    in_range_s;
    logic                    hit_s;
    logic [DATA_WIDTH-1:0]   bit_mask_s;
    logic [DMEM_MERGE_W-1:0] merged_s;
    logic [DATA_WIDTH-1:0]   next_s;
    logic [DATA_WIDTH-1:0]   rdata_r;

    assign in_range_s = ({1'b0, raddr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));
    assign hit_s      = (raddr == waddr);

    // Forwarding mask, byte-merge and range gating of the next read value
    always_comb begin
        bit_mask_s = '0;
        for (int i = 0; i < DATA_BYTE; i++) begin
            bit_mask_s[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{hit_s && wen[i]}};
        end
        merged_s = byte_merge(DMEM_MERGE_W'(old_word), DMEM_MERGE_W'(wdata),
                              DMEM_MERGE_W'(bit_mask_s));
        if (in_range_s) begin
            next_s = merged_s[DATA_WIDTH-1:0];
        end else begin
            next_s = '0;
        end
    end

    // Read data register: loads on accept, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (accept) begin
            rdata_r <= next_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_mp.sv
// dmem_mp: multi-read-port data memory with byte-masked write and zero-fill init.
//   clk, rst_n : clock, async active-low reset
//   en/ready   : request handshake; accepted when en && ready
//   wen/waddr/wdata : byte-masked write (wen==0 means read-only request)
//   raddr      : NUM_RD packed read addresses
//   rvalid     : one-cycle pulse, read data valid one cycle after accept
//   rdata      : NUM_RD packed registered read data
//   init_done  : array fully zero-filled, requests now accepted
module dmem_mp
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = DMEM_DATA_WIDTH,
    parameter int BYTE_WIDTH    = DMEM_BYTE_WIDTH,
    parameter int ADDR_WIDTH    = DMEM_ADDR_WIDTH,
    parameter int RAM_DEPTH     = DMEM_RAM_DEPTH,
    parameter int NUM_RD        = DMEM_NUM_RD,
    parameter int INIT_ON_RESET = 1,
    parameter int DATA_BYTE     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         ready,
    input  logic [DATA_BYTE-1:0]         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic                         rvalid,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic                         init_done
);

    localparam logic [0:0] RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_RUN;

    logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];
    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  ready_r;
    logic                  init_done_r;
    logic                  rvalid_r;
    logic                  accept_s;
    logic                  waddr_ok_s;

    assign accept_s   = en && ready_r && (state_r == S_RUN);
    assign waddr_ok_s = ({1'b0, waddr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));

    // Init FSM: zero-fill sweep, then terminal RUN with ready/init_done set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RESET_STATE;
            cnt_r       <= '0;
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (cnt_r == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        // Flags rise together with the state so the first RUN cycle is ready
                        state_r     <= S_RUN;
                        cnt_r       <= '0;
                        ready_r     <= 1'b1;
                        init_done_r <= 1'b1;
                    end else begin
                        cnt_r       <= cnt_r + ADDR_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    ready_r     <= 1'b1;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= S_INIT;
                    cnt_r       <= '0;
                    ready_r     <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Array write: zero-fill during INIT, byte-masked in-range writes in RUN
    always_ff @(posedge clk) begin
        if (state_r == S_INIT) begin
            mem_r[cnt_r] <= '0;
        end else if (accept_s && waddr_ok_s) begin
            for (int i = 0; i < DATA_BYTE; i++) begin
                if (wen[i]) begin
                    mem_r[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read-valid pulse, one cycle after each accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= accept_s;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr_k_s;
        logic [DATA_WIDTH-1:0] old_word_s;

        assign raddr_k_s  = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        // Out-of-range addresses are zeroed inside the lane
        assign old_word_s = mem_r[raddr_k_s];

        dmem_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .BYTE_WIDTH (BYTE_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RAM_DEPTH  (RAM_DEPTH),
            .DATA_BYTE  (DATA_BYTE)
        ) u_rd_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .accept   (accept_s),
            .raddr    (raddr_k_s),
            .waddr    (waddr),
            .wen      (wen),
            .wdata    (wdata),
            .old_word (old_word_s),
            .rdata    (rdata[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign ready     = ready_r;
    assign init_done = init_done_r;
    assign rvalid    = rvalid_r;

endmodule

// File: doc/dmem_mp.md
Name: dmem_mp

Overview:
- Parametrised multi-read-port data memory for the core's load/store unit and the page-table walker.
- NUM_RD independent read ports and one byte-masked write port.
- Synchronous (registered) reads with write-first forwarding.
- After reset, an init FSM zero-fills the array before any request is accepted, so page-table walks never see X.

Parameters:
DATA_WIDTH, 32, word width in bits
BYTE_WIDTH, 8, bits per write-mask lane
ADDR_WIDTH, 10, word address width
RAM_DEPTH, 1024, number of words (≤ 2^ADDR_WIDTH)
NUM_RD, 2, number of read ports (≥1)
INIT_ON_RESET, 1, 1 = zero-fill after reset; 0 = go straight to RUN
DATA_BYTE, DATA_WIDTH/BYTE_WIDTH, derived; must divide exactly

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active-low
en  input  1  request valid
ready  output  1  request accepted when en && ready
wen  input  DATA_BYTE  per-byte write enable; 0 = read-only request
waddr  input  ADDR_WIDTH  write word address
wdata  input  DATA_WIDTH  write data
raddr  input  NUM_RD*ADDR_WIDTH  read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
rvalid  output  1  read data valid, one-cycle pulse
rdata  output  NUM_RD*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
init_done  output  1  high once the array is fully initialised

Behaviour:
- Reset (async assert, sync release) values:
  - rvalid=0, rdata=0, ready=0, init_done=0, init counter=0.
  - State = INIT if INIT_ON_RESET, else RUN.
- FSM INIT:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - When cnt==RAM_DEPTH-1 is written, go to RUN. Total INIT duration: exactly RAM_DEPTH cycles.
  - ready=0 throughout; en is ignored.
- FSM RUN:
  - ready=1 and init_done=1 (both registered, rising in the first RUN cycle).
  - RUN is terminal until reset.
- Accept: en && ready at a rising edge.
  - Write: for each byte i with wen[i]=1, mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata byte i.
  - Read: every accepted request, including one with a write, samples all NUM_RD raddr.
  - rdata is updated and rvalid=1 on the following cycle (latency 1). Back-to-back accepts give continuous rvalid.
  - With no accept, rvalid=0 and rdata holds its last value.
- Write-first forwarding: if raddr[k]==waddr in the same accepted cycle, byte i of rdata[k] is the new wdata byte when wen[i]=1, otherwise the old memory byte.
  - Applies independently per port; multiple ports may hit the same address.
- Out-of-range address (≥ RAM_DEPTH):
  - Write is dropped.
  - Read returns 0 with rvalid still asserted.
- Reset mid-operation:
  - Any pending rvalid is cleared.
  - The FSM restarts INIT from cnt=0.
  - Memory contents are not guaranteed until init_done rises again.
- Reads never return 0 merely because a write is present.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum {S_INIT, S_RUN}.
  - Default width/depth constants shared with the LSU and PTW.
  - Helper function for the byte-merge used in forwarding.
- One natural sub-module, dmem_rd_port:
  - One registered read lane with forwarding merge and range check.
  - Instantiated NUM_RD times via generate.
- The array, write logic and init FSM stay in the top level.

Test Plan:
- Init: release rst_n with INIT_ON_RESET=1, RAM_DEPTH=1024 -> ready=0 for exactly 1024 cycles, then ready=init_done=1; reading addresses 0, 511 and 1023 returns 0x00000000.
- Dual read: write 0xDEADBEEF to 5 and 0x12345678 to 9 (wen=4'hF); then read raddr0=5, raddr1=9 -> next cycle rvalid=1, rdata0=0xDEADBEEF, rdata1=0x12345678.
- Byte mask: mem[3]=0x11223344; write wen=4'b0101, wdata=0xAABBCCDD -> subsequent read of 3 returns 0x11BB33DD.
- Forwarding: mem[7]=0x00000000; same cycle write 7, wen=4'b1100, wdata=0xCAFEF00D, with raddr0=7, raddr1=8 -> rdata0=0xCAFE0000, rdata1=old mem[8].
- Stall/hold: accept a read, then deassert en for 3 cycles -> rvalid one-cycle pulse, rdata holds value; en during INIT -> no write takes effect (verify after init_done).
- Reset mid-stream: assert rst_n=0 while rvalid=1 -> rvalid and rdata drop to 0 immediately; after release, INIT repeats for RAM_DEPTH cycles and a previously written address reads 0.
